seq_divider_core: RTL and testbench

- Iterative radix-2 restoring divider acting as the responder on the execution unit's divider stream interface.
- Drop-in for the vendor divider IP. Accepts divisor/dividend on two slave streams and returns {quotient, remainder} on one master stream with no backpressure.
- Instantiated inside the execution-element divide unit; the initiator pulses both input valids for one cycle and waits for dout valid.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 23 ++
 rtl/seq_divider_core.sv | 144 ++++++++++++++
 tb/tb_seq_divider_core.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        ITER,
        FIX
    } state_t;

    localparam int DEF_WIDTH = 32;

    // Counter must hold 0..WIDTH-1 with headroom for the full operand width.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on a (WIDTH+1)-bit partial remainder.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0] i_rem,
    input  logic [WIDTH:0] i_dvs,
    input  logic           i_bit,
    output logic [WIDTH:0] o_rem,
    output logic           o_qbit
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_diff;

    // i_rem < i_dvs on entry, so the difference always fits WIDTH+2 signed bits.
    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {1'b0, i_dvs};
    assign o_qbit  = ~w_diff[WIDTH+1];
    assign o_rem   = o_qbit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];

endmodule

// File: rtl/seq_divider_core.sv
// Iterative radix-2 restoring divider with stream-style operand/result handshakes.
//   state | meaning
//   IDLE  | ready for operands, outputs hold last result
//   PREP  | signs recorded, magnitudes and div-by-zero flag formed
//   ITER  | one quotient bit per cycle, WIDTH cycles
//   FIX   | signs applied, result strobed for one cycle
module seq_divider_core
    import div_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SIGNED = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               s_axis_divisor_tvalid,
    input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
    output logic               s_axis_divisor_tready,
    input  logic               s_axis_dividend_tvalid,
    input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
    output logic               s_axis_dividend_tready,
    output logic               m_axis_dout_tvalid,
    output logic [2*WIDTH-1:0] m_axis_dout_tdata,
    output logic               m_axis_dout_tuser
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH:0]     r_dsm;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_q;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic               r_valid;
    logic [2*WIDTH-1:0] r_data;
    logic               r_user;

    logic               w_ready;
    logic               w_accept;
    logic               w_sd;
    logic               w_ss;
    logic [WIDTH:0]     w_ext_dvd;
    logic [WIDTH:0]     w_ext_dvs;
    logic [WIDTH:0]     w_mag_dvd;
    logic [WIDTH:0]     w_mag_dvs;
    logic [WIDTH:0]     w_step_rem;
    logic               w_step_q;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    assign w_ready  = (r_state == IDLE) && rstn;
    assign w_accept = w_ready && s_axis_divisor_tvalid && s_axis_dividend_tvalid;

    assign s_axis_divisor_tready  = w_ready;
    assign s_axis_dividend_tready = w_ready;

    // WIDTH+1-bit magnitudes keep the most negative operand representable.
    assign w_sd      = (SIGNED != 0) && r_dvd[WIDTH-1];
    assign w_ss      = (SIGNED != 0) && r_dvs[WIDTH-1];
    assign w_ext_dvd = {w_sd, r_dvd};
    assign w_ext_dvs = {w_ss, r_dvs};
    assign w_mag_dvd = w_sd ? -w_ext_dvd : w_ext_dvd;
    assign w_mag_dvs = w_ss ? -w_ext_dvs : w_ext_dvs;

    assign w_q_fix = r_neg_q ? -r_q : r_q;
    assign w_r_fix = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem  (r_rem),
        .i_dvs  (r_dsm),
        .i_bit  (r_q[WIDTH-1]),
        .o_rem  (w_step_rem),
        .o_qbit (w_step_q)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_dsm   <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_user  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_dvd   <= s_axis_dividend_tdata;
                        r_dvs   <= s_axis_divisor_tdata;
                        r_state <= PREP;
                    end
                end
                PREP: begin
                    r_neg_q <= w_sd ^ w_ss;
                    r_neg_r <= w_sd;
                    r_div0  <= (r_dvs == '0);
                    r_dsm   <= w_mag_dvs;
                    r_q     <= w_mag_dvd[WIDTH-1:0];
                    // Top magnitude bit is always zero; it seeds the remainder.
                    r_rem   <= {{WIDTH{1'b0}}, w_mag_dvd[WIDTH]};
                    r_cnt   <= '0;
                    r_state <= ITER;
                end
                ITER: begin
                    r_rem <= w_step_rem;
                    r_q   <= {r_q[WIDTH-2:0], w_step_q};
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= FIX;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (r_div0) begin
                        r_data <= {{WIDTH{1'b1}}, r_dvd};
                    end else begin
                        r_data <= {w_q_fix, w_r_fix};
                    end
                    r_user  <= r_div0;
                    r_valid <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m_axis_dout_tvalid = r_valid;
    assign m_axis_dout_tdata  = r_data;
    assign m_axis_dout_tuser  = r_user;

endmodule

// File: tb/tb_seq_divider_core.sv
// Directed bench for seq_divider_core: signed and unsigned instances share stimulus,
// an arithmetic reference model is compared every cycle, plus literal spot checks.
module tb_seq_divider_core;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic          vs   = 1'b0;
    logic          vd   = 1'b0;
    logic [W-1:0]  ds   = '0;
    logic [W-1:0]  dd   = '0;

    logic          s_rdy_s, s_rdy_d, s_val, s_user;
    logic [2*W-1:0] s_data;
    logic          u_rdy_s, u_rdy_d, u_val, u_user;
    logic [2*W-1:0] u_data;

    int total = 0;
    int bad   = 0;

    seq_divider_core #(.WIDTH(W), .SIGNED(1)) dut_s (
        .clk(clk), .rstn(rstn),
        .s_axis_divisor_tvalid(vs), .s_axis_divisor_tdata(ds), .s_axis_divisor_tready(s_rdy_s),
        .s_axis_dividend_tvalid(vd), .s_axis_dividend_tdata(dd), .s_axis_dividend_tready(s_rdy_d),
        .m_axis_dout_tvalid(s_val), .m_axis_dout_tdata(s_data), .m_axis_dout_tuser(s_user)
    );

    seq_divider_core #(.WIDTH(W), .SIGNED(0)) dut_u (
        .clk(clk), .rstn(rstn),
        .s_axis_divisor_tvalid(vs), .s_axis_divisor_tdata(ds), .s_axis_divisor_tready(u_rdy_s),
        .s_axis_dividend_tvalid(vd), .s_axis_dividend_tdata(dd), .s_axis_dividend_tready(u_rdy_d),
        .m_axis_dout_tvalid(u_val), .m_axis_dout_tdata(u_data), .m_axis_dout_tuser(u_user)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] model_s(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {q[31:0], r[31:0]};
    endfunction

    function automatic logic [63:0] model_u(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        return {a / b, a % b};
    endfunction

    // Reference model: an op accepted at cycle n produces its strobe in cycle n+LAT.
    int          cyc     = 0;
    bit          have_op = 1'b0;
    int          due     = 0;
    logic [63:0] exp_s, exp_u;
    logic        exp_z;
    logic [63:0] last_s  = '0;
    logic [63:0] last_u  = '0;
    logic        last_z  = 1'b0;
    bit          chk_en  = 1'b0;

    always @(posedge clk) begin
        int k;
        k   = cyc;
        cyc = k + 1;
        if (!rstn) begin
            have_op = 1'b0;
            last_s  = '0;
            last_u  = '0;
            last_z  = 1'b0;
            chk_en  = 1'b1;
        end else begin
            if (have_op && cyc == due) begin
                last_s = exp_s;
                last_u = exp_u;
                last_z = exp_z;
            end
            if ((!have_op || k >= due) && vs && vd) begin
                exp_s   = model_s(dd, ds);
                exp_u   = model_u(dd, ds);
                exp_z   = (ds == '0);
                have_op = 1'b1;
                due     = cyc + LAT;
            end
        end
    end

    always @(negedge clk) begin
        logic ev, er;
        if (chk_en) begin
            ev = have_op && (cyc == due);
            er = rstn && (!have_op || cyc >= due);
            check("tready_divisor_s",  64'(s_rdy_s), 64'(er));
            check("tready_dividend_s", 64'(s_rdy_d), 64'(er));
            check("tready_divisor_u",  64'(u_rdy_s), 64'(er));
            check("tready_dividend_u", 64'(u_rdy_d), 64'(er));
            check("tvalid_s", 64'(s_val), 64'(ev));
            check("tvalid_u", 64'(u_val), 64'(ev));
            check("tdata_s", s_data, last_s);
            check("tdata_u", u_data, last_u);
            check("tuser_s", 64'(s_user), 64'(last_z));
            check("tuser_u", 64'(u_user), 64'(last_z));
        end
    end

    task automatic pulse(input logic [31:0] a, input logic [31:0] b, input bit both, output int acc);
        @(posedge clk);
        #1;
        dd = a;
        ds = b;
        vd = 1'b1;
        vs = both;
        @(posedge clk);
        #1;
        acc = cyc;
        vd  = 1'b0;
        vs  = 1'b0;
    endtask

    task automatic wait_result(input int acc, output int lat, output logic [63:0] rs,
                               output logic [63:0] ru, output logic z);
        lat = -1;
        rs  = '0;
        ru  = '0;
        z   = 1'b0;
        for (int i = 0; i < LAT + 10 && lat < 0; i++) begin
            @(negedge clk);
            if (s_val) begin
                lat = cyc - acc;
                rs  = s_data;
                ru  = u_data;
                z   = s_user;
            end
        end
    endtask

    task automatic count_valids(input int n, output int cnt, output logic [63:0] rs);
        cnt = 0;
        rs  = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (s_val) begin
                cnt++;
                rs = s_data;
            end
        end
    endtask

    initial begin
        int          acc, lat, cnt;
        logic [63:0] rs, ru;
        logic        z;

        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tready", 64'(s_rdy_s), 64'd0);
        check("reset_tvalid", 64'(s_val), 64'd0);
        check("reset_tdata", s_data, 64'd0);
        check("reset_tuser", 64'(s_user), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("idle_tready", 64'(s_rdy_d), 64'd1);

        pulse(32'd100, 32'd7, 1'b1, acc);
        wait_result(acc, lat, rs, ru, z);
        check("lat_100_7", 64'(lat), 64'd34);
        check("q_r_100_7", rs, {32'd14, 32'd2});
        check("tuser_100_7", 64'(z), 64'd0);

        pulse(32'hFFFF_FF9C, 32'd7, 1'b1, acc);
        wait_result(acc, lat, rs, ru, z);
        check("signed_m100_7", rs, {32'hFFFF_FFF2, 32'hFFFF_FFFE});
        check("unsigned_m100_7", ru, {32'h2492_4916, 32'h0000_0002});

        pulse(32'd5, 32'd0, 1'b1, acc);
        wait_result(acc, lat, rs, ru, z);
        check("lat_div0", 64'(lat), 64'd34);
        check("q_r_div0_s", rs, {32'hFFFF_FFFF, 32'h0000_0005});
        check("q_r_div0_u", ru, {32'hFFFF_FFFF, 32'h0000_0005});
        check("tuser_div0", 64'(z), 64'd1);

        pulse(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, acc);
        wait_result(acc, lat, rs, ru, z);
        check("intmin_m1", rs, {32'h8000_0000, 32'h0000_0000});
        check("tuser_intmin", 64'(z), 64'd0);

        pulse(32'd9, 32'd3, 1'b0, acc);
        @(negedge clk);
        check("lone_valid_tready", 64'(s_rdy_s), 64'd1);
        count_valids(LAT + 6, cnt, rs);
        check("lone_valid_results", 64'(cnt), 64'd0);

        pulse(32'd50, 32'd5, 1'b1, acc);
        repeat (5) @(posedge clk);
        pulse(32'd77, 32'd3, 1'b1, acc);
        count_valids(LAT + 20, cnt, rs);
        check("busy_pulse_results", 64'(cnt), 64'd1);
        check("busy_pulse_data", rs, {32'd10, 32'd0});

        pulse(32'd1000, 32'd3, 1'b1, acc);
        repeat (11) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("post_reset_tready", 64'(s_rdy_s), 64'd1);
        check("post_reset_tdata", s_data, 64'd0);
        count_valids(LAT + 6, cnt, rs);
        check("aborted_results", 64'(cnt), 64'd0);

        pulse(32'd1, 32'd1, 1'b1, acc);
        wait_result(acc, lat, rs, ru, z);
        check("lat_1_1", 64'(lat), 64'd34);
        check("q_r_1_1", rs, {32'd1, 32'd0});

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
